// File: rtl/event_stat_deserializer.sv
// event_stat_deserializer: rebuilds 4-word event-stat frames into peak/timestamp records with framing-error and optional timestamp-order checks.
//   Ports: clk, rst (sync, active-high); s_data/s_valid/s_last/s_ready = 32-bit framed input stream;
//          m_peak/m_timestamp/m_valid/m_ready = record output register; frame_err/frame_err_cnt = framing-error pulse/count;
//          ts_err/ts_err_cnt = timestamp-regression pulse/count, built only with EVENT_STAT_TS_CHECK_EN defined.
module event_stat_deserializer #(
  parameter int TS_W      = 40,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [63:0]          m_peak,
  output logic [TS_W-1:0]      m_timestamp,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] frame_err_cnt,
  output logic                 ts_err,
  output logic [ERR_CNT_W-1:0] ts_err_cnt
);
  typedef enum logic {ASSEMBLE, DROP} state_t;
  state_t                 state_q, state_d;
  logic [1:0]             wcnt_q, wcnt_d;
  logic [31:0]            w0_q, w1_q, w2_q;
  logic [63:0]            m_peak_q;
  logic [TS_W-1:0]        m_ts_q, new_ts;
  logic                   m_valid_q, frame_err_q, acc, load, ferr;
  logic [ERR_CNT_W-1:0]   frame_err_cnt_q;
  // Only the final word can collide with a held record, so only it stalls.
  assign s_ready = !rst && !(state_q == ASSEMBLE && wcnt_q == 2'd3 && m_valid_q && !m_ready);
  assign acc     = s_valid && s_ready;
  assign new_ts  = {s_data[TS_W-33:0], w2_q};
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    load    = 1'b0;
    ferr    = 1'b0;
    if (acc) begin
      if (state_q == DROP) begin
        state_d = s_last ? ASSEMBLE : DROP;
      end else if (wcnt_q == 2'd3) begin
        load    = s_last;
        ferr    = !s_last;
        state_d = s_last ? ASSEMBLE : DROP;
        wcnt_d  = 2'd0;
      end else begin
        ferr   = s_last;
        wcnt_d = s_last ? 2'd0 : wcnt_q + 2'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ASSEMBLE;
      wcnt_q          <= 2'd0;
      w0_q            <= '0;
      w1_q            <= '0;
      w2_q            <= '0;
      m_peak_q        <= '0;
      m_ts_q          <= '0;
      m_valid_q       <= 1'b0;
      frame_err_q     <= 1'b0;
      frame_err_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      wcnt_q          <= wcnt_d;
      if (acc && state_q == ASSEMBLE && wcnt_q == 2'd0) w0_q <= s_data;
      if (acc && state_q == ASSEMBLE && wcnt_q == 2'd1) w1_q <= s_data;
      if (acc && state_q == ASSEMBLE && wcnt_q == 2'd2) w2_q <= s_data;
      if (load) begin
        m_peak_q <= {w1_q, w0_q};
        m_ts_q   <= new_ts;
      end
      m_valid_q       <= load || (m_valid_q && !m_ready);
      frame_err_q     <= ferr;
      frame_err_cnt_q <= frame_err_cnt_q + ERR_CNT_W'(ferr && !(&frame_err_cnt_q));
    end
  end
  assign m_peak        = m_peak_q;
  assign m_timestamp   = m_ts_q;
  assign m_valid       = m_valid_q;
  assign frame_err     = frame_err_q;
  assign frame_err_cnt = frame_err_cnt_q;
`ifdef EVENT_STAT_TS_CHECK_EN
  logic [TS_W-1:0]      prev_ts_q;
  logic                 have_prev_q, ts_err_q, ts_bad;
  logic [ERR_CNT_W-1:0] ts_err_cnt_q;
  assign ts_bad = load && have_prev_q && new_ts <= prev_ts_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ts_q    <= '0;
      have_prev_q  <= 1'b0;
      ts_err_q     <= 1'b0;
      ts_err_cnt_q <= '0;
    end else begin
      if (load) begin
        prev_ts_q   <= new_ts;
        have_prev_q <= 1'b1;
      end
      ts_err_q     <= ts_bad;
      ts_err_cnt_q <= ts_err_cnt_q + ERR_CNT_W'(ts_bad && !(&ts_err_cnt_q));
    end
  end
  assign ts_err     = ts_err_q;
  assign ts_err_cnt = ts_err_cnt_q;
`else
  assign ts_err     = 1'b0;
  assign ts_err_cnt = '0;
`endif
endmodule

// File: tb/tb_event_stat_deserializer.sv
// tb_event_stat_deserializer: directed self-checking bench for event_stat_deserializer.
module tb_event_stat_deserializer;
  logic        clk = 1'b0;
  logic        rst, s_valid, s_last, m_ready, frame_err, ts_err, s_ready, m_valid;
  logic [31:0] s_data;
  logic [63:0] m_peak;
  logic [39:0] m_timestamp;
  logic [15:0] frame_err_cnt, ts_err_cnt;
  int          errors = 0;
  int          checks = 0;
`ifdef EVENT_STAT_TS_CHECK_EN
  localparam bit TSC = 1'b1;
`else
  localparam bit TSC = 1'b0;
`endif
  event_stat_deserializer #(.TS_W(40), .ERR_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_peak(m_peak), .m_timestamp(m_timestamp), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err), .frame_err_cnt(frame_err_cnt), .ts_err(ts_err), .ts_err_cnt(ts_err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (!s_ready) chk("ready_timeout", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask
  task automatic send_frame(input logic [63:0] pk, input logic [63:0] ts);
    send(pk[31:0], 1'b0);
    send(pk[63:32], 1'b0);
    send(ts[31:0], 1'b0);
    send(ts[63:32], 1'b1);
  endtask
  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    tick(); tick();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_peak", m_peak, 64'd0);
    chk("rst_m_ts", 64'(m_timestamp), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_ferr_cnt", 64'(frame_err_cnt), 64'd0);
    rst = 1'b0;
    tick();
    // good frame
    send_frame(64'h0003_0002_0001_0000, 64'd100);
    chk("good_valid", 64'(m_valid), 64'd1);
    chk("good_peak", m_peak, 64'h0003_0002_0001_0000);
    chk("good_ts", 64'(m_timestamp), 64'd100);
    chk("good_ferr_cnt", 64'(frame_err_cnt), 64'd0);
    tick();
    chk("good_drain", 64'(m_valid), 64'd0);
    // backpressure
    m_ready = 1'b0;
    send_frame(64'h1111_2222_3333_4444, 64'h12_0000_00C8);
    chk("bp_a_valid", 64'(m_valid), 64'd1);
    chk("bp_a_ts", 64'(m_timestamp), 64'h12_0000_00C8);
    send(32'hAAAA_BBBB, 1'b0);
    send(32'hCCCC_DDDD, 1'b0);
    chk("bp_w2_ready", 64'(s_ready), 64'd1);
    send(32'h0000_012C, 1'b0);
    s_data = 32'h0000_0034; s_last = 1'b1; s_valid = 1'b1;
    #1;
    chk("bp_w3_stall", 64'(s_ready), 64'd0);
    tick(); tick(); tick();
    chk("bp_hold_ready", 64'(s_ready), 64'd0);
    chk("bp_hold_valid", 64'(m_valid), 64'd1);
    chk("bp_hold_peak", m_peak, 64'h1111_2222_3333_4444);
    chk("bp_hold_ts", 64'(m_timestamp), 64'h12_0000_00C8);
    m_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    chk("bp_b_valid", 64'(m_valid), 64'd1);
    chk("bp_b_peak", m_peak, 64'hCCCC_DDDD_AAAA_BBBB);
    chk("bp_b_ts", 64'(m_timestamp), 64'h34_0000_012C);
    tick();
    chk("bp_no_dup", 64'(m_valid), 64'd0);
    // short frame
    send(32'h5555_5555, 1'b0);
    send(32'h6666_6666, 1'b1);
    chk("short_pulse", 64'(frame_err), 64'd1);
    chk("short_cnt", 64'(frame_err_cnt), 64'd1);
    chk("short_no_rec", 64'(m_valid), 64'd0);
    tick();
    chk("short_pulse_end", 64'(frame_err), 64'd0);
    send_frame(64'h0008_0007_0006_0005, 64'd5);
    chk("short_next_ts", 64'(m_timestamp), 64'd5);
    chk("short_next_peak", m_peak, 64'h0008_0007_0006_0005);
    tick();
    chk("short_one_rec", 64'(m_valid), 64'd0);
    // long frame
    send(32'h1, 1'b0); send(32'h2, 1'b0); send(32'h3, 1'b0); send(32'h4, 1'b0);
    chk("long_pulse", 64'(frame_err), 64'd1);
    chk("long_cnt", 64'(frame_err_cnt), 64'd2);
    chk("long_no_rec", 64'(m_valid), 64'd0);
    send(32'h5, 1'b0); send(32'h6, 1'b1);
    chk("long_drop_valid", 64'(m_valid), 64'd0);
    chk("long_drop_ferr", 64'(frame_err), 64'd0);
    send_frame(64'h0009_000A_000B_000C, 64'd7);
    chk("long_next_valid", 64'(m_valid), 64'd1);
    chk("long_next_peak", m_peak, 64'h0009_000A_000B_000C);
    chk("long_next_ts", 64'(m_timestamp), 64'd7);
    chk("long_next_cnt", 64'(frame_err_cnt), 64'd2);
    // reset mid-frame with a held record
    m_ready = 1'b0;
    send(32'hDEAD_BEEF, 1'b0);
    send(32'hFEED_F00D, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_peak", m_peak, 64'd0);
    chk("mid_rst_ts", 64'(m_timestamp), 64'd0);
    chk("mid_rst_ferr_cnt", 64'(frame_err_cnt), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b0; m_ready = 1'b1;
    tick();
    // timestamp sequence 10, 20, 20, 15 starting right after reset
    send_frame(64'h0004_0003_0002_0001, 64'd10);
    chk("rst_next_peak", m_peak, 64'h0004_0003_0002_0001);
    chk("rst_next_ts", 64'(m_timestamp), 64'd10);
    chk("rst_next_ferr", 64'(frame_err), 64'd0);
    chk("rst_next_ferr_cnt", 64'(frame_err_cnt), 64'd0);
    chk("ts1_err", 64'(ts_err), 64'd0);
    send_frame(64'h1, 64'd20);
    chk("ts2_valid", 64'(m_valid), 64'd1);
    chk("ts2_err", 64'(ts_err), 64'd0);
    send_frame(64'h2, 64'd20);
    chk("ts3_valid", 64'(m_valid), 64'd1);
    chk("ts3_err", 64'(ts_err), 64'(TSC));
    tick();
    chk("ts3_err_end", 64'(ts_err), 64'd0);
    send_frame(64'h3, 64'd15);
    chk("ts4_valid", 64'(m_valid), 64'd1);
    chk("ts4_ts", 64'(m_timestamp), 64'd15);
    chk("ts4_err", 64'(ts_err), 64'(TSC));
    chk("ts_cnt", 64'(ts_err_cnt), TSC ? 64'd2 : 64'd0);
    chk("ts_ferr_cnt", 64'(frame_err_cnt), 64'd0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/event_stat_deserializer.md
Name: event_stat_deserializer

Overview:
Receiving end of the event-statistics word stream. Accepts 32-bit words with valid/ready/last framing and reassembles each 4-word frame into one event-stat record (four 16-bit peaks plus a TS_W-bit timestamp). Presents the record on a valid/ready output register for downstream logic or debug-probe capture. Detects and counts framing errors; optionally checks that timestamps are monotonic.

Parameters:
TS_W, 40, timestamp width; legal range 33..64.
ERR_CNT_W, 16, width of the saturating error counters.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
s_data  in  32  input word
s_valid  in  1  input word valid
s_last  in  1  marks final word of frame
s_ready  out  1  input word accepted when s_valid & s_ready
m_peak  out  64  peak[i] at bits [16i+15:16i], i=0..3
m_timestamp  out  TS_W  record timestamp
m_valid  out  1  record valid
m_ready  in  1  downstream accepts record
frame_err  out  1  one-cycle pulse per framing error
frame_err_cnt  out  ERR_CNT_W  saturating framing-error count
ts_err  out  1  one-cycle pulse per timestamp regression (feature only, else 0)
ts_err_cnt  out  ERR_CNT_W  saturating regression count (feature only, else 0)

Behaviour:
- Frame layout:
  - word0 = {peak1, peak0}
  - word1 = {peak3, peak2}
  - word2 = timestamp[31:0]
  - word3 = timestamp[TS_W-1:32] in the low bits; upper padding bits are ignored, not checked.
- State ASSEMBLE, word counter wcnt 0..3:
  - Words 0-2 are captured into assembly registers and wcnt increments. The output register is not touched.
- Word 3 accepted with s_last=1:
  - Assembly contents move to the output register; m_valid=1 on the next cycle (latency 1 clk from the accepting edge).
  - wcnt returns to 0.
- s_last=1 on wcnt 0..2:
  - Frame error. Partial frame is discarded; wcnt=0; frame_err pulses; frame_err_cnt increments. No record is emitted.
- wcnt=3 word accepted with s_last=0:
  - Frame error (pulse, count) and move to state DROP.
- State DROP:
  - Accept and discard words, s_ready=1.
  - The word with s_last=1 is discarded too, then return to ASSEMBLE with wcnt=0.
- s_ready:
  - 0 while rst=1.
  - Otherwise 1, except in ASSEMBLE with wcnt=3 while m_valid=1 and m_ready=0.
  - Words 0-2 are never stalled by the output.
- Output register:
  - Holds its value stable while m_valid & !m_ready.
  - Cleared of valid on m_ready when no new record loads.
  - A simultaneous drain and load in the same cycle gives back-to-back records with no bubble.
- Counters saturate at all-ones and do not wrap.
- Reset:
  - m_valid=0, m_peak=0, m_timestamp=0.
  - Both pulses 0, both counters 0.
  - wcnt=0, state ASSEMBLE.
  - A partial frame in flight is lost. The first word after reset is treated as word0.

Optional Feature:
Macro EVENT_STAT_TS_CHECK_EN.
- Defined:
  - On each record load, compare its timestamp with the last loaded timestamp (unsigned).
  - If new <= previous: ts_err pulses for one cycle, aligned with the m_valid rise of that record, and ts_err_cnt increments.
  - The record is still emitted.
  - The first record after reset is never flagged (a have_prev flag is cleared by reset).
- Undefined:
  - No comparison logic or previous-timestamp register is built.
  - ts_err and ts_err_cnt are tied to 0.

Test Plan:
- Good frame: words 0x0001_0000, 0x0003_0002, 0x0000_0064, 0x0000_0000 (last on word 4), m_ready=1 -> one cycle after the last word, m_valid=1, m_peak=0x0003_0002_0001_0000, m_timestamp=100; frame_err_cnt=0.
- Backpressure: two good frames back-to-back, m_ready=0 -> first record held stable; s_ready drops only on the second frame's word3; raising m_ready yields the second record the next cycle, with no loss or duplication.
- Short frame: 2 words with last on word 2, then a good frame with ts=5 -> frame_err pulses once, frame_err_cnt=1, exactly one record emitted (ts=5).
- Long frame: 6 words, last on word 6, then a good frame -> frame_err_cnt=1, words 5-6 discarded in DROP, next good frame emitted correctly.
- With EVENT_STAT_TS_CHECK_EN: frames with ts 10, 20, 20, 15 -> ts_err pulses on the 3rd and 4th records, ts_err_cnt=2, all 4 records emitted. Without the macro -> ts_err_cnt stays 0.
- Reset mid-frame after 2 words, then a good frame -> all outputs 0 during reset, and the next frame decodes correctly with no frame_err.
